// File: rtl/oled_spi_sink.sv
// Receive-side mirror of the PmodOLED 4-wire SPI link: reassembles bytes, decodes the
// SSD1306 addressing subset and keeps a readable copy of the display framebuffer.
module oled_spi_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int NPAGES      = 4,
  parameter int NCOLS       = 128,
  localparam int PAGE_W     = $clog2(NPAGES),
  localparam int COL_W      = $clog2(NCOLS),
  localparam int AW         = PAGE_W + COL_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              oled_cs,
  input  logic              oled_sdin,
  input  logic              oled_sclk,
  input  logic              oled_dc,
  output logic              byte_valid,
  output logic [7:0]        byte_out,
  output logic              byte_is_data,
  output logic              display_on,
  output logic [PAGE_W-1:0] cur_page,
  output logic [COL_W-1:0]  cur_col,
  output logic [15:0]       cmd_count,
  output logic [15:0]       data_count,
  output logic              frame_err,
  input  logic [AW-1:0]     rd_addr,
  output logic [7:0]        rd_data
);

  typedef enum logic [1:0] {DEC_CMD, DEC_ARG1, DEC_ARG2} dec_state_t;
  typedef enum logic [1:0] {PEND_MODE, PEND_COL, PEND_PAGE, PEND_IGN} pend_t;

  logic [SYNC_STAGES-1:0] cs_sync, sdin_sync, sclk_sync, dc_sync;
  logic                   cs_s, sdin_s, sclk_s, dc_s;
  logic                   sclk_prev, cs_prev;
  logic                   sclk_rise, cs_rise;
  logic [6:0]             shift_q;
  logic [2:0]             bit_cnt;

  dec_state_t             dec_q, dec_nx;
  pend_t                  pend_q, pend_nx;
  logic [1:0]             mode;
  logic [COL_W-1:0]       col_start, col_end, col_inc, col_adv;
  logic [PAGE_W-1:0]      page_start, page_end, page_inc, page_adv;
  logic                   col_wrap, page_wrap;

  logic [7:0]             fb [NPAGES*NCOLS];

  // Stage 0: synchronizers and edge detect
  always_ff @(posedge CLK) begin
    if (RST) begin
      cs_sync   <= '1;
      sdin_sync <= '0;
      sclk_sync <= '0;
      dc_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], oled_cs};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], oled_sdin};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], oled_sclk};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], oled_dc};
      sclk_prev <= sclk_s;
      cs_prev   <= cs_s;
    end
  end

  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sdin_s    = sdin_sync[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign dc_s      = dc_sync[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_prev & sclk_s & ~cs_s;
  assign cs_rise   = ~cs_prev & cs_s;

  // Decoder next state: a data byte always forces the decoder back to CMD
  always_comb begin
    dec_nx  = dec_q;
    pend_nx = pend_q;
    if (byte_valid) begin
      if (byte_is_data) begin
        dec_nx = DEC_CMD;
      end else begin
        case (dec_q)
          DEC_CMD: begin
            case (byte_out)
              8'h20: begin dec_nx = DEC_ARG1; pend_nx = PEND_MODE; end
              8'h21: begin dec_nx = DEC_ARG1; pend_nx = PEND_COL;  end
              8'h22: begin dec_nx = DEC_ARG1; pend_nx = PEND_PAGE; end
              8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                dec_nx  = DEC_ARG1;
                pend_nx = PEND_IGN;
              end
              default: ;
            endcase
          end
          DEC_ARG1: dec_nx = (pend_q == PEND_COL || pend_q == PEND_PAGE) ? DEC_ARG2 : DEC_CMD;
          default:  dec_nx = DEC_CMD;
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dec_q  <= DEC_CMD;
      pend_q <= PEND_IGN;
    end else begin
      dec_q  <= dec_nx;
      pend_q <= pend_nx;
    end
  end

  // Pointer advance after a data byte, per addressing mode (3 behaves as page mode)
  always_comb begin
    col_wrap  = (cur_col == col_end);
    page_wrap = (cur_page == page_end);
    col_inc   = col_wrap  ? col_start  : cur_col + COL_W'(1);
    page_inc  = page_wrap ? page_start : cur_page + PAGE_W'(1);
    col_adv   = cur_col;
    page_adv  = cur_page;
    case (mode)
      2'd0: begin
        col_adv = col_inc;
        if (col_wrap) page_adv = page_inc;
      end
      2'd1: begin
        page_adv = page_inc;
        if (page_wrap) col_adv = col_inc;
      end
      default: col_adv = col_inc;
    endcase
  end

  // Stage 1: byte assembly; stage 2: command/data effects on the byte_valid cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      shift_q      <= '0;
      bit_cnt      <= '0;
      byte_valid   <= 1'b0;
      byte_out     <= '0;
      byte_is_data <= 1'b0;
      display_on   <= 1'b0;
      cur_page     <= '0;
      cur_col      <= '0;
      cmd_count    <= '0;
      data_count   <= '0;
      frame_err    <= 1'b0;
      mode         <= 2'd2;
      col_start    <= '0;
      col_end      <= COL_W'(NCOLS - 1);
      page_start   <= '0;
      page_end     <= PAGE_W'(NPAGES - 1);
    end else begin
      byte_valid <= 1'b0;
      if (sclk_rise) begin
        if (bit_cnt == 3'd7) begin
          byte_out     <= {shift_q, sdin_s};
          byte_is_data <= dc_s;
          byte_valid   <= 1'b1;
          bit_cnt      <= '0;
        end else begin
          shift_q <= {shift_q[5:0], sdin_s};
          bit_cnt <= bit_cnt + 3'd1;
        end
      end else if (cs_rise && bit_cnt != 3'd0) begin
        bit_cnt   <= '0;
        frame_err <= 1'b1;
      end

      if (byte_valid) begin
        if (byte_is_data) begin
          data_count <= data_count + 16'd1;
          cur_col    <= col_adv;
          cur_page   <= page_adv;
          if (dec_q != DEC_CMD) frame_err <= 1'b1;
        end else begin
          cmd_count <= cmd_count + 16'd1;
          case (dec_q)
            DEC_CMD: begin
              if (byte_out[7:4] == 4'h0)
                cur_col[3:0] <= byte_out[3:0];
              else if (byte_out[7:4] == 4'h1)
                cur_col[COL_W-1:4] <= byte_out[COL_W-5:0];
              else if (byte_out[7:3] == 5'b10110)
                cur_page <= byte_out[PAGE_W-1:0];
              else if (byte_out[7:1] == 7'b1010111)
                display_on <= byte_out[0];
            end
            DEC_ARG1: begin
              case (pend_q)
                PEND_MODE: mode <= byte_out[1:0];
                PEND_COL: begin
                  col_start <= byte_out[COL_W-1:0];
                  cur_col   <= byte_out[COL_W-1:0];
                end
                PEND_PAGE: begin
                  page_start <= byte_out[PAGE_W-1:0];
                  cur_page   <= byte_out[PAGE_W-1:0];
                end
                default: ;
              endcase
            end
            DEC_ARG2: begin
              if (pend_q == PEND_COL)  col_end  <= byte_out[COL_W-1:0];
              if (pend_q == PEND_PAGE) page_end <= byte_out[PAGE_W-1:0];
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Framebuffer: contents survive reset; read port returns old data on a same-address write
  always_ff @(posedge CLK) begin
    if (byte_valid && byte_is_data)
      fb[{cur_page, cur_col}] <= byte_out;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      rd_data <= '0;
    else
      rd_data <= fb[rd_addr];
  end

endmodule

// File: tb/tb_oled_spi_sink.sv
// Directed bench for oled_spi_sink: drives SPI bytes bit by bit and checks decode,
// counters, pointers and framebuffer contents against hand-computed values.
module tb_oled_spi_sink;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        oled_cs = 1'b1;
  logic        oled_sdin = 1'b0;
  logic        oled_sclk = 1'b0;
  logic        oled_dc = 1'b0;
  logic        byte_valid;
  logic [7:0]  byte_out;
  logic        byte_is_data;
  logic        display_on;
  logic [1:0]  cur_page;
  logic [6:0]  cur_col;
  logic [15:0] cmd_count;
  logic [15:0] data_count;
  logic        frame_err;
  logic [8:0]  rd_addr = '0;
  logic [7:0]  rd_data;

  int n_cmp = 0;
  int n_err = 0;
  int bv_count = 0;
  logic [7:0] last_byte = '0;
  logic       last_dc = 1'b0;

  oled_spi_sink #(.SYNC_STAGES(2), .NPAGES(4), .NCOLS(128)) dut (
    .CLK(CLK), .RST(RST),
    .oled_cs(oled_cs), .oled_sdin(oled_sdin), .oled_sclk(oled_sclk), .oled_dc(oled_dc),
    .byte_valid(byte_valid), .byte_out(byte_out), .byte_is_data(byte_is_data),
    .display_on(display_on), .cur_page(cur_page), .cur_col(cur_col),
    .cmd_count(cmd_count), .data_count(data_count), .frame_err(frame_err),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (byte_valid) begin
      bv_count  <= bv_count + 1;
      last_byte <= byte_out;
      last_dc   <= byte_is_data;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    wait_clk(3);
    RST = 1'b0;
  endtask

  // One SPI frame: CS low, nbits MSB-first, optionally CS high afterwards
  task automatic spi_bits(input logic [7:0] b, input logic dc, input int nbits, input bit end_frame);
    oled_cs = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      oled_sclk = 1'b0;
      oled_sdin = b[7-i];
      oled_dc   = dc;
      wait_clk(4);
      oled_sclk = 1'b1;
      wait_clk(4);
    end
    oled_sclk = 1'b0;
    wait_clk(4);
    if (end_frame) begin
      oled_cs = 1'b1;
      wait_clk(6);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    spi_bits(b, 1'b0, 8, 1'b1);
  endtask

  task automatic send_data(input logic [7:0] b);
    spi_bits(b, 1'b1, 8, 1'b1);
  endtask

  task automatic fb_read(input logic [8:0] addr, output logic [7:0] d);
    @(negedge CLK);
    rd_addr = addr;
    @(negedge CLK);
    d = rd_data;
  endtask

  initial begin
    logic [7:0] d;
    int bv0;

    // Reset held 3 cycles, outputs sampled before release
    wait_clk(3);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_out",   32'(byte_out),   32'd0);
    check("rst_display_on", 32'(display_on), 32'd0);
    check("rst_page",       32'(cur_page),   32'd0);
    check("rst_col",        32'(cur_col),    32'd0);
    check("rst_cmd_count",  32'(cmd_count),  32'd0);
    check("rst_data_count", 32'(data_count), 32'd0);
    check("rst_frame_err",  32'(frame_err),  32'd0);
    check("rst_rd_data",    32'(rd_data),    32'd0);
    RST = 1'b0;

    send_data(8'h11);
    fb_read(9'd0, d);
    check("t1_fb0",   32'(d),          32'h11);
    check("t1_col",   32'(cur_col),    32'd1);
    check("t1_dcnt",  32'(data_count), 32'd1);

    do_reset();
    bv0 = bv_count;
    send_cmd(8'hAF);
    check("t2_nbytes",  32'(bv_count - bv0), 32'd1);
    check("t2_byte",    32'(last_byte),      32'hAF);
    check("t2_is_data", 32'(last_dc),        32'd0);
    check("t2_disp",    32'(display_on),     32'd1);
    check("t2_ccnt",    32'(cmd_count),      32'd1);

    do_reset();
    send_cmd(8'hB2);
    send_cmd(8'h05);
    send_cmd(8'h13);
    send_data(8'hAA);
    send_data(8'h55);
    fb_read(9'h135, d);
    check("t3_fb135", 32'(d), 32'hAA);
    fb_read(9'h136, d);
    check("t3_fb136", 32'(d), 32'h55);
    check("t3_page",  32'(cur_page),   32'd2);
    check("t3_col",   32'(cur_col),    32'd55);
    check("t3_dcnt",  32'(data_count), 32'd2);
    check("t3_ccnt",  32'(cmd_count),  32'd3);

    send_cmd(8'h20); send_cmd(8'h00);
    send_cmd(8'h21); send_cmd(8'h7E); send_cmd(8'h7F);
    send_cmd(8'h22); send_cmd(8'h03); send_cmd(8'h03);
    send_data(8'h01); send_data(8'h02); send_data(8'h03);
    fb_read(9'd510, d);
    check("t4_fb510", 32'(d), 32'h03);
    fb_read(9'd511, d);
    check("t4_fb511", 32'(d), 32'h02);
    check("t4_col",   32'(cur_col),   32'd127);
    check("t4_page",  32'(cur_page),  32'd3);
    check("t4_ccnt",  32'(cmd_count), 32'd11);
    check("t4_ferr",  32'(frame_err), 32'd0);

    // Truncated byte then a full command
    send_cmd(8'hAF);
    check("t5_disp_on", 32'(display_on), 32'd1);
    bv0 = bv_count;
    spi_bits(8'hFF, 1'b0, 5, 1'b1);
    check("t5_partial_nbytes", 32'(bv_count - bv0), 32'd0);
    check("t5_ferr",           32'(frame_err),      32'd1);
    send_cmd(8'hAE);
    check("t5_nbytes", 32'(bv_count - bv0), 32'd1);
    check("t5_byte",   32'(last_byte),      32'hAE);
    check("t5_disp",   32'(display_on),     32'd0);

    // Data byte while an argument is pending
    do_reset();
    send_cmd(8'h81);
    send_data(8'h7F);
    fb_read(9'd0, d);
    check("t6_fb0",  32'(d),         32'h7F);
    check("t6_ferr", 32'(frame_err), 32'd1);
    check("t6_col",  32'(cur_col),   32'd1);
    send_cmd(8'hAF);
    check("t6_disp", 32'(display_on), 32'd1);
    check("t6_ccnt", 32'(cmd_count),  32'd2);

    // Vertical addressing wraps page then advances column
    do_reset();
    send_cmd(8'h20); send_cmd(8'h01);
    send_data(8'h0A); send_data(8'h0B); send_data(8'h0C);
    send_data(8'h0D); send_data(8'h0E);
    fb_read(9'd128, d);
    check("t7_fb128", 32'(d), 32'h0B);
    fb_read(9'd384, d);
    check("t7_fb384", 32'(d), 32'h0D);
    fb_read(9'd1, d);
    check("t7_fb1",   32'(d), 32'h0E);
    check("t7_page",  32'(cur_page), 32'd1);
    check("t7_col",   32'(cur_col),  32'd1);

    // Reset mid-byte loses the partial byte without flagging an error
    spi_bits(8'hF0, 1'b0, 4, 1'b0);
    do_reset();
    oled_cs = 1'b1;
    wait_clk(8);
    check("t8_ferr", 32'(frame_err), 32'd0);
    bv0 = bv_count;
    send_cmd(8'hAF);
    check("t8_nbytes", 32'(bv_count - bv0), 32'd1);
    check("t8_byte",   32'(last_byte),      32'hAF);
    check("t8_disp",   32'(display_on),     32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
